// File: rtl/spi_mosi_tx_if.sv
// Port bundle for the SPI mode-0 transmit engine: start handshake, status and SPI pins.
interface spi_mosi_tx_if #(
    parameter int DATA_W = 8
);
    // Handshake: a request is taken on any clk_i edge where start_i=1 and the
    // engine is idle (busy_o=0, including the done_o cycle); it is never queued.
    logic              start_i;
    logic [DATA_W-1:0] data_i;
    logic              busy_o;
    logic              done_o;
    logic              sclk_o;
    logic              mosi_o;
    logic              cs_n_o;
    logic              shift_o;
    logic [1:0]        state_dbg;

    modport master (
        output start_i, data_i,
        input  busy_o, done_o, sclk_o, mosi_o, cs_n_o, shift_o, state_dbg
    );

    modport slave (
        input  start_i, data_i,
        output busy_o, done_o, sclk_o, mosi_o, cs_n_o, shift_o, state_dbg
    );
endinterface

// File: rtl/spi_mosi_tx.sv
// SPI master transmit engine, mode 0, MSB first, with a receive sample strobe
// aligned to every SCLK rising edge.
module spi_mosi_tx #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 5
) (
    input  logic         clk_i,
    input  logic         rst,
    spi_mosi_tx_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SETUP, TRANSFER, HOLD} state_t;

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W);

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic              cs_n_q, cs_n_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              shift_q, shift_d;
    logic              div_tc;

    assign div_tc = (div_q == DIV_LAST);

    always_ff @(posedge clk_i) begin
        if (!rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            shift_q <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            cs_n_q  <= cs_n_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        cs_n_d  = cs_n_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        shift_d = 1'b0;

        case (state_q)
            IDLE: begin
                div_d = '0;
                bit_d = '0;
                if (bus.start_i) begin
                    shreg_d = bus.data_i;
                    mosi_d  = bus.data_i[DATA_W-1];
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = SETUP;
                end
            end
            // The end of the setup interval is itself the first rising edge.
            SETUP: begin
                if (div_tc) begin
                    div_d   = '0;
                    sclk_d  = 1'b1;
                    shift_d = 1'b1;
                    bit_d   = bit_q + 1'b1;
                    state_d = TRANSFER;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            TRANSFER: begin
                if (div_tc) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    if (!sclk_q) begin
                        shift_d = 1'b1;
                        bit_d   = bit_q + 1'b1;
                    end else if (bit_q == BIT_LAST) begin
                        mosi_d  = 1'b0;
                        state_d = HOLD;
                    end else begin
                        shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
                        mosi_d  = shreg_q[DATA_W-2];
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            HOLD: begin
                if (div_tc) begin
                    div_d   = '0;
                    bit_d   = '0;
                    cs_n_d  = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.sclk_o    = sclk_q;
    assign bus.mosi_o    = mosi_q;
    assign bus.cs_n_o    = cs_n_q;
    assign bus.busy_o    = busy_q;
    assign bus.done_o    = done_q;
    assign bus.shift_o   = shift_q;
    assign bus.state_dbg = state_q;
endmodule
